// File: rtl/mem_rw_arbiter_if.sv
// Bundle of requester-side (A/B) and memory-controller-side signals for mem_rw_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_rw_arbiter_if #(
  parameter int AW = 6,
  parameter int NW = 4
) ();
  logic          i_req_a,      i_req_b;
  logic          i_rw_a,       i_rw_b;
  logic [AW-1:0] i_addr_a,     i_addr_b;
  logic [NW-1:0] i_num_b_a,    i_num_b_b;
  logic          o_gnt_a,      o_gnt_b;
  logic [7:0]    i_wr_data_a,  i_wr_data_b;
  logic          i_wr_valid_a, i_wr_valid_b;
  logic          o_wr_done_a,  o_wr_done_b;
  logic [7:0]    o_rd_data_a,  o_rd_data_b;
  logic          o_rd_valid_a, o_rd_valid_b;
  logic          i_rd_done_a,  i_rd_done_b;
  logic          o_cmpl_a,     o_cmpl_b;
  logic          o_err_a,      o_err_b;
  logic [2:0]    o_err_code_a, o_err_code_b;
  logic          i_err_ack_a,  i_err_ack_b;

  logic          o_mc_wr_req, o_mc_rd_req;
  logic [AW-1:0] o_mc_addr;
  logic [NW-1:0] o_mc_num_b;
  logic          i_mc_ack;
  logic [7:0]    o_mc_wr_data;
  logic          o_mc_wr_valid;
  logic          i_mc_wr_done;
  logic [7:0]    i_mc_rd_data;
  logic          i_mc_rd_valid;
  logic          o_mc_rd_done;
  logic          i_mc_err;
  logic [2:0]    i_mc_err_code;
  logic          o_mc_err_ack;

  modport slave (
    input  i_req_a, i_req_b, i_rw_a, i_rw_b, i_addr_a, i_addr_b, i_num_b_a, i_num_b_b,
    input  i_wr_data_a, i_wr_data_b, i_wr_valid_a, i_wr_valid_b, i_rd_done_a, i_rd_done_b,
    input  i_err_ack_a, i_err_ack_b,
    output o_gnt_a, o_gnt_b, o_wr_done_a, o_wr_done_b, o_rd_data_a, o_rd_data_b,
    output o_rd_valid_a, o_rd_valid_b, o_cmpl_a, o_cmpl_b, o_err_a, o_err_b,
    output o_err_code_a, o_err_code_b,
    output o_mc_wr_req, o_mc_rd_req, o_mc_addr, o_mc_num_b, o_mc_wr_data, o_mc_wr_valid,
    output o_mc_rd_done, o_mc_err_ack,
    input  i_mc_ack, i_mc_wr_done, i_mc_rd_data, i_mc_rd_valid, i_mc_err, i_mc_err_code
  );

  modport master (
    output i_req_a, i_req_b, i_rw_a, i_rw_b, i_addr_a, i_addr_b, i_num_b_a, i_num_b_b,
    output i_wr_data_a, i_wr_data_b, i_wr_valid_a, i_wr_valid_b, i_rd_done_a, i_rd_done_b,
    output i_err_ack_a, i_err_ack_b,
    input  o_gnt_a, o_gnt_b, o_wr_done_a, o_wr_done_b, o_rd_data_a, o_rd_data_b,
    input  o_rd_valid_a, o_rd_valid_b, o_cmpl_a, o_cmpl_b, o_err_a, o_err_b,
    input  o_err_code_a, o_err_code_b,
    input  o_mc_wr_req, o_mc_rd_req, o_mc_addr, o_mc_num_b, o_mc_wr_data, o_mc_wr_valid,
    input  o_mc_rd_done, o_mc_err_ack,
    output i_mc_ack, i_mc_wr_done, i_mc_rd_data, i_mc_rd_valid, i_mc_err, i_mc_err_code
  );
endinterface

// File: rtl/mem_rw_arbiter.sv
// Two-requester arbiter in front of a single-port memory R/W controller.
// Round-robin by default; define MEM_ARB_FIXED_PRI_EN to make requester A always win ties.
//
// state  | meaning
// IDLE   | no owner, waiting for a request
// REQ    | owner granted, controller request asserted until i_mc_ack
// XFER   | byte handshakes routed owner <-> controller, counting bytes
// ERR    | controller error reported to owner, waiting for acknowledge
module mem_rw_arbiter #(
  parameter int AW = 6,
  parameter int NW = 4
) (
  input logic i_clk,
  input logic i_reset,
  mem_rw_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state;
  logic          owner;    // 0 = A, 1 = B
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [NW-1:0] num_q;
  logic [NW-1:0] cnt;
  logic [2:0]    code_q;

  logic any_req, win_b, xfer, active, done, byte_ev;
  logic wr_valid_own, rd_done_own, err_ack_own;
  logic [7:0] wr_data_own;

  assign any_req = bus.i_req_a | bus.i_req_b;

`ifdef MEM_ARB_FIXED_PRI_EN
  assign win_b = ~bus.i_req_a;
`else
  logic last_b;
  assign win_b = bus.i_req_b & (~bus.i_req_a | ~last_b);
`endif

  assign xfer         = (state == S_XFER);
  assign active       = (state != S_IDLE);
  assign wr_valid_own = owner ? bus.i_wr_valid_b : bus.i_wr_valid_a;
  assign wr_data_own  = owner ? bus.i_wr_data_b  : bus.i_wr_data_a;
  assign rd_done_own  = owner ? bus.i_rd_done_b  : bus.i_rd_done_a;
  assign err_ack_own  = owner ? bus.i_err_ack_b  : bus.i_err_ack_a;
  assign done         = (cnt == num_q);
  assign byte_ev      = rw_q ? bus.i_mc_wr_done : (bus.i_mc_rd_valid & rd_done_own);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      owner  <= 1'b0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      num_q  <= '0;
      cnt    <= '0;
      code_q <= 3'd0;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_b <= 1'b1;
`endif
    end else begin
      // Error code tracks the latest non-zero value seen while the controller is engaged.
      if ((state == S_REQ || state == S_XFER) && bus.i_mc_err_code != 3'd0)
        code_q <= bus.i_mc_err_code;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner  <= win_b;
            rw_q   <= win_b ? bus.i_rw_b      : bus.i_rw_a;
            addr_q <= win_b ? bus.i_addr_b    : bus.i_addr_a;
            num_q  <= win_b ? bus.i_num_b_b   : bus.i_num_b_a;
            code_q <= 3'd0;
            state  <= S_REQ;
`ifndef MEM_ARB_FIXED_PRI_EN
            last_b <= win_b;
`endif
          end
        end
        S_REQ: begin
          if (bus.i_mc_err) begin
            state <= S_ERR;
          end else if (bus.i_mc_ack) begin
            state <= S_XFER;
            cnt   <= '0;
          end
        end
        S_XFER: begin
          if (bus.i_mc_err)   state <= S_ERR;
          else if (done)      state <= S_IDLE;
          else if (byte_ev)   cnt   <= cnt + 1'b1;
        end
        S_ERR: begin
          if (err_ack_own) begin
            state  <= S_IDLE;
            code_q <= 3'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_gnt_a       = active & ~owner;
  assign bus.o_gnt_b       = active &  owner;
  assign bus.o_mc_wr_req   = (state == S_REQ) &  rw_q;
  assign bus.o_mc_rd_req   = (state == S_REQ) & ~rw_q;
  assign bus.o_mc_addr     = addr_q;
  assign bus.o_mc_num_b    = num_q;

  assign bus.o_mc_wr_data  = xfer ? wr_data_own : 8'd0;
  assign bus.o_mc_wr_valid = xfer & wr_valid_own;
  assign bus.o_mc_rd_done  = xfer & rd_done_own;
  assign bus.o_wr_done_a   = xfer & ~owner & bus.i_mc_wr_done;
  assign bus.o_wr_done_b   = xfer &  owner & bus.i_mc_wr_done;
  assign bus.o_rd_valid_a  = xfer & ~owner & bus.i_mc_rd_valid;
  assign bus.o_rd_valid_b  = xfer &  owner & bus.i_mc_rd_valid;
  assign bus.o_rd_data_a   = (xfer & ~owner) ? bus.i_mc_rd_data : 8'd0;
  assign bus.o_rd_data_b   = (xfer &  owner) ? bus.i_mc_rd_data : 8'd0;

  assign bus.o_cmpl_a      = xfer & done & ~bus.i_mc_err & ~owner;
  assign bus.o_cmpl_b      = xfer & done & ~bus.i_mc_err &  owner;
  assign bus.o_err_a       = (state == S_ERR) & ~owner;
  assign bus.o_err_b       = (state == S_ERR) &  owner;
  assign bus.o_err_code_a  = bus.o_gnt_a ? code_q : 3'd0;
  assign bus.o_err_code_b  = bus.o_gnt_b ? code_q : 3'd0;
  assign bus.o_mc_err_ack  = (state == S_ERR) & err_ack_own;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed bench for mem_rw_arbiter: table of bursts plus error, zero-length and reset sequences.
module tb_mem_rw_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_rw_arbiter_if #(.AW(6), .NW(4)) bus ();
  mem_rw_arbiter #(.AW(6), .NW(4)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit         ra, rb, rw;
    logic [3:0] n;
    logic [5:0] addr;
    bit         exp_b;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req_a = 0;  bus.i_req_b = 0;  bus.i_rw_a = 0;  bus.i_rw_b = 0;
    bus.i_addr_a = 0; bus.i_addr_b = 0; bus.i_num_b_a = 0; bus.i_num_b_b = 0;
    bus.i_wr_data_a = 0; bus.i_wr_data_b = 0; bus.i_wr_valid_a = 0; bus.i_wr_valid_b = 0;
    bus.i_rd_done_a = 0; bus.i_rd_done_b = 0; bus.i_err_ack_a = 0; bus.i_err_ack_b = 0;
    bus.i_mc_ack = 0; bus.i_mc_wr_done = 0; bus.i_mc_rd_data = 0; bus.i_mc_rd_valid = 0;
    bus.i_mc_err = 0; bus.i_mc_err_code = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0] nw;
    logic [5:0] aw;
    string tag;
    tag = $sformatf("v%0d", idx);
    nw = v.exp_b ? 4'(v.n + 4'd1) : v.n;
    aw = v.exp_b ? (v.addr ^ 6'h2a) : v.addr;
    bus.i_req_a = v.ra; bus.i_req_b = v.rb;
    bus.i_rw_a = v.rw;  bus.i_rw_b = v.rw;
    bus.i_addr_a = v.addr; bus.i_addr_b = v.addr ^ 6'h2a;
    bus.i_num_b_a = v.n;   bus.i_num_b_b = 4'(v.n + 4'd1);
    tick();
    bus.i_req_a = 0; bus.i_req_b = 0;
    chk({tag, " gnt_a"}, 32'(bus.o_gnt_a), 32'(!v.exp_b));
    chk({tag, " gnt_b"}, 32'(bus.o_gnt_b), 32'(v.exp_b));
    chk({tag, " mc_wr_req"}, 32'(bus.o_mc_wr_req), 32'(v.rw));
    chk({tag, " mc_rd_req"}, 32'(bus.o_mc_rd_req), 32'(!v.rw));
    chk({tag, " mc_addr"}, 32'(bus.o_mc_addr), 32'(aw));
    chk({tag, " mc_num_b"}, 32'(bus.o_mc_num_b), 32'(nw));
    bus.i_mc_ack = 1;
    tick();
    bus.i_mc_ack = 0;
    chk({tag, " req drop"}, 32'(bus.o_mc_wr_req | bus.o_mc_rd_req), 32'd0);
    for (int i = 0; i < int'(nw); i++) begin
      chk({tag, " early cmpl"}, 32'(bus.o_cmpl_a | bus.o_cmpl_b), 32'd0);
      if (v.rw) begin
        if (v.exp_b) begin bus.i_wr_data_b = 8'(8'ha0 + i); bus.i_wr_valid_b = 1; end
        else         begin bus.i_wr_data_a = 8'(8'ha0 + i); bus.i_wr_valid_a = 1; end
        bus.i_mc_wr_done = 1;
        #1;
        chk({tag, " mc_wr_data"}, 32'(bus.o_mc_wr_data), 32'(8'(8'ha0 + i)));
        chk({tag, " mc_wr_valid"}, 32'(bus.o_mc_wr_valid), 32'd1);
        chk({tag, " wr_done own"}, 32'(v.exp_b ? bus.o_wr_done_b : bus.o_wr_done_a), 32'd1);
        chk({tag, " wr_done other"}, 32'(v.exp_b ? bus.o_wr_done_a : bus.o_wr_done_b), 32'd0);
      end else begin
        bus.i_mc_rd_data = 8'(8'h50 + i);
        bus.i_mc_rd_valid = 1;
        if (v.exp_b) bus.i_rd_done_b = 1; else bus.i_rd_done_a = 1;
        #1;
        chk({tag, " rd_valid own"}, 32'(v.exp_b ? bus.o_rd_valid_b : bus.o_rd_valid_a), 32'd1);
        chk({tag, " rd_valid other"}, 32'(v.exp_b ? bus.o_rd_valid_a : bus.o_rd_valid_b), 32'd0);
        chk({tag, " rd_data own"}, 32'(v.exp_b ? bus.o_rd_data_b : bus.o_rd_data_a), 32'(8'(8'h50 + i)));
        chk({tag, " mc_rd_done"}, 32'(bus.o_mc_rd_done), 32'd1);
      end
      tick();
      bus.i_wr_valid_a = 0; bus.i_wr_valid_b = 0; bus.i_mc_wr_done = 0;
      bus.i_mc_rd_valid = 0; bus.i_rd_done_a = 0; bus.i_rd_done_b = 0;
      #1;
    end
    chk({tag, " cmpl own"}, 32'(v.exp_b ? bus.o_cmpl_b : bus.o_cmpl_a), 32'd1);
    chk({tag, " cmpl other"}, 32'(v.exp_b ? bus.o_cmpl_a : bus.o_cmpl_b), 32'd0);
    chk({tag, " addr held"}, 32'(bus.o_mc_addr), 32'(aw));
    tick();
    chk({tag, " idle gnt"}, 32'({bus.o_gnt_a, bus.o_gnt_b}), 32'd0);
    chk({tag, " idle cmpl"}, 32'(bus.o_cmpl_a | bus.o_cmpl_b), 32'd0);
  endtask

  initial begin
`ifdef MEM_ARB_FIXED_PRI_EN
    vecs[0] = '{ra:1, rb:0, rw:1, n:4'd3, addr:6'h05, exp_b:0};
    vecs[1] = '{ra:1, rb:1, rw:1, n:4'd1, addr:6'h11, exp_b:0};
    vecs[2] = '{ra:1, rb:1, rw:0, n:4'd2, addr:6'h22, exp_b:0};
    vecs[3] = '{ra:1, rb:1, rw:1, n:4'd1, addr:6'h30, exp_b:0};
    vecs[4] = '{ra:0, rb:1, rw:0, n:4'd2, addr:6'h3f, exp_b:1};
`else
    vecs[0] = '{ra:1, rb:0, rw:1, n:4'd3, addr:6'h05, exp_b:0};
    vecs[1] = '{ra:1, rb:1, rw:1, n:4'd1, addr:6'h11, exp_b:1};
    vecs[2] = '{ra:1, rb:1, rw:0, n:4'd2, addr:6'h22, exp_b:0};
    vecs[3] = '{ra:1, rb:1, rw:1, n:4'd1, addr:6'h30, exp_b:1};
    vecs[4] = '{ra:0, rb:1, rw:0, n:4'd2, addr:6'h3f, exp_b:1};
`endif
    clear_inputs();
    rst = 1;
    tick();
    tick();
    chk("rst gnt", 32'({bus.o_gnt_a, bus.o_gnt_b}), 32'd0);
    chk("rst mc_req", 32'({bus.o_mc_wr_req, bus.o_mc_rd_req}), 32'd0);
    chk("rst mc_addr", 32'(bus.o_mc_addr), 32'd0);
    chk("rst mc_num_b", 32'(bus.o_mc_num_b), 32'd0);
    chk("rst err", 32'({bus.o_err_a, bus.o_err_b, bus.o_cmpl_a, bus.o_cmpl_b}), 32'd0);
    rst = 0;
    tick();

    for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

    // Error during A write: B waits until A acknowledges, then a zero-length read for B.
    bus.i_req_a = 1; bus.i_rw_a = 1; bus.i_addr_a = 6'h0c; bus.i_num_b_a = 4'd2;
    bus.i_rw_b = 0; bus.i_addr_b = 6'h07; bus.i_num_b_b = 4'd0;
    tick();
    bus.i_req_a = 0;
    chk("err gnt_a", 32'(bus.o_gnt_a), 32'd1);
    chk("err code pre", 32'(bus.o_err_code_a), 32'd0);
    bus.i_mc_ack = 1;
    tick();
    bus.i_mc_ack = 0;
    bus.i_mc_err = 1; bus.i_mc_err_code = 3'd1; bus.i_req_b = 1;
    tick();
    bus.i_mc_err = 0; bus.i_mc_err_code = 3'd0;
    chk("err err_a", 32'(bus.o_err_a), 32'd1);
    chk("err code_a", 32'(bus.o_err_code_a), 32'd1);
    chk("err err_b", 32'(bus.o_err_b), 32'd0);
    chk("err mc_req", 32'({bus.o_mc_wr_req, bus.o_mc_rd_req}), 32'd0);
    chk("err ack idle", 32'(bus.o_mc_err_ack), 32'd0);
    tick();
    chk("err hold gnt", 32'({bus.o_gnt_a, bus.o_gnt_b}), 32'b10);
    bus.i_err_ack_a = 1;
    #1;
    chk("err mc_err_ack", 32'(bus.o_mc_err_ack), 32'd1);
    tick();
    bus.i_err_ack_a = 0;
    #1;
    chk("err exit gnt", 32'({bus.o_gnt_a, bus.o_gnt_b}), 32'd0);
    chk("err exit flags", 32'({bus.o_err_a, bus.o_mc_err_ack}), 32'd0);
    tick();
    bus.i_req_b = 0;
    chk("z gnt_b", 32'(bus.o_gnt_b), 32'd1);
    chk("z rd_req", 32'(bus.o_mc_rd_req), 32'd1);
    chk("z code_b", 32'(bus.o_err_code_b), 32'd0);
    chk("z num_b", 32'(bus.o_mc_num_b), 32'd0);
    bus.i_mc_ack = 1;
    tick();
    bus.i_mc_ack = 0;
    #1;
    chk("z cmpl_b", 32'(bus.o_cmpl_b), 32'd1);
    chk("z no bytes", 32'({bus.o_rd_valid_b, bus.o_mc_rd_done}), 32'd0);
    tick();
    chk("z idle", 32'({bus.o_gnt_b, bus.o_cmpl_b}), 32'd0);

    // Reset in the middle of an A write burst.
    bus.i_req_a = 1; bus.i_rw_a = 1; bus.i_addr_a = 6'h15; bus.i_num_b_a = 4'd3;
    tick();
    bus.i_req_a = 0;
    bus.i_mc_ack = 1;
    tick();
    bus.i_mc_ack = 0;
    bus.i_wr_valid_a = 1; bus.i_wr_data_a = 8'h77; bus.i_mc_wr_done = 1;
    tick();
    rst = 1;
    #1;
    chk("rst mid gnt_a", 32'(bus.o_gnt_a), 32'd0);
    chk("rst mid mc_wr_valid", 32'(bus.o_mc_wr_valid), 32'd0);
    chk("rst mid mc_addr", 32'(bus.o_mc_addr), 32'd0);
    chk("rst mid mc_num_b", 32'(bus.o_mc_num_b), 32'd0);
    clear_inputs();
    tick();
    rst = 0;
    bus.i_req_b = 1; bus.i_rw_b = 0; bus.i_num_b_b = 4'd0; bus.i_addr_b = 6'h09;
    tick();
    bus.i_req_b = 0;
    chk("post rst gnt", 32'({bus.o_gnt_a, bus.o_gnt_b}), 32'b01);
    chk("post rst addr", 32'(bus.o_mc_addr), 32'h09);
    bus.i_mc_ack = 1;
    tick();
    bus.i_mc_ack = 0;
    tick();
    chk("post rst done", 32'(bus.o_gnt_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_rw_arbiter.md
# mem_rw_arbiter

Two-requester arbiter in front of the shared single-port memory R/W controller. Requesters A and B each present a read or write burst (address, byte count); the arbiter grants one at a time, drives the controller's request/address/count, routes the byte handshakes between owner and controller, and forwards controller errors to the owner until acknowledged. Round-robin by default; fixed priority optional.

## Interface
Parameters:
- AW, 6, address width
- NW, 4, byte-count width

Ports (x = a or b; each x line is one port per requester):
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_req_x  in  1  burst request; held until o_gnt_x
- i_rw_x  in  1  1 = write, 0 = read; sampled with request
- i_addr_x  in  AW  burst address; sampled at grant
- i_num_b_x  in  NW  burst byte count; sampled at grant
- o_gnt_x  out  1  level: x owns the controller (REQ through ERR)
- i_wr_data_x  in  8  write byte
- i_wr_valid_x  in  1  write byte valid
- o_wr_done_x  out  1  write byte accepted
- o_rd_data_x  out  8  read byte
- o_rd_valid_x  out  1  read byte valid
- i_rd_done_x  in  1  read byte consumed
- o_cmpl_x  out  1  one-cycle pulse: burst finished without error
- o_err_x  out  1  error pending for x
- o_err_code_x  out  3  captured error code
- i_err_ack_x  in  1  error acknowledge
- o_mc_wr_req, o_mc_rd_req  out  1  controller requests (registered)
- o_mc_addr  out  AW  latched owner address
- o_mc_num_b  out  NW  latched owner count
- i_mc_ack  in  1  controller accepted request
- o_mc_wr_data  out  8, o_mc_wr_valid  out  1  routed write byte
- i_mc_wr_done  in  1  controller write accept
- i_mc_rd_data  in  8, i_mc_rd_valid  in  1  controller read byte
- o_mc_rd_done  out  1  routed read consume
- i_mc_err  in  1, i_mc_err_code  in  3  controller error
- o_mc_err_ack  out  1  routed error acknowledge

## Operation
- States: IDLE, REQ, XFER, ERR. Reset: IDLE, all outputs 0, owner = none, RR pointer = A preferred, addr/count/code registers 0.
- IDLE: if any i_req_x, pick winner (only one requesting → it; both → side not granted last). Latch owner, rw, addr, num_b; next REQ. Pointer updates to "last = winner".
- REQ: o_gnt_owner = 1; o_mc_wr_req = rw, o_mc_rd_req = ~rw. On i_mc_ack → XFER, requests drop to 0 in XFER.
- XFER: combinational routing owner↔controller; non-owner outputs and non-owner inputs ignored/0. Byte counter (NW bits, cleared on entry) increments on i_mc_wr_done (write) or i_mc_rd_valid & o_mc_rd_done (read). When count == latched num_b → IDLE, o_cmpl_owner pulses that cycle, o_gnt drops next cycle. num_b = 0 → exits on first XFER cycle.
- Error: i_mc_err high in REQ or XFER → ERR (takes precedence over completion). o_err_code_owner holds last non-zero i_mc_err_code sampled in REQ/XFER (0 if none). In ERR: o_err_owner = 1, o_mc_err_ack = i_err_ack_owner (comb). i_err_ack_owner → IDLE; code cleared on exit.
- i_req_x dropped after grant: ignored; burst continues. Requests never preempt an active owner.
- o_mc_addr/o_mc_num_b constant for whole ownership.

## Timing
- Grant latency: request seen in IDLE at edge n → o_gnt_x and o_mc_*_req high at n+1.
- Controller request is asserted only in REQ; never high in XFER/ERR, so controller cannot chain a second burst.
- Routing adds zero cycles; counter/state registered.
- Back-to-back: after IDLE return, next grant one cycle later (min 1 IDLE cycle between bursts).
- i_reset asserted mid-burst: immediate IDLE, o_gnt_x/o_mc_* to 0 asynchronously.

## Configuration
- MEM_ARB_FIXED_PRI_EN defined: A always wins simultaneous requests; RR pointer removed.
- Undefined: round-robin as above.

## Test plan
- Reset, A write req num_b=3 addr=0x05 → o_gnt_a at n+1, o_mc_wr_req one REQ cycle, three i_mc_wr_done → o_cmpl_a pulse, IDLE.
- A and B request same cycle twice (RR build) → A then B then A; with MEM_ARB_FIXED_PRI_EN → A every time.
- B read num_b=2 → o_rd_valid_b mirrors i_mc_rd_valid, o_rd_data_b = i_mc_rd_data, o_rd_valid_a = 0, completion after 2 rd_done.
- A write, i_mc_err with code 3'd1 in XFER → o_err_a = 1, code 1, B request held off until i_err_ack_a; o_mc_err_ack pulses with it.
- num_b = 0 read → REQ, one XFER cycle, o_cmpl pulse, no byte handshakes.
- i_reset mid-XFER → o_gnt_a, o_mc_* = 0 immediately; after release, B request granted first (pointer reset).
